bcd_counter_n: RTL and testbench
================================

BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 The block SHALL take parameter DIGITS, default 4, the number of BCD digits (1..8).
REQ-002 The block SHALL take parameter SCAN_DIV, default 16, the clock cycles per digit in scan mode (>=2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-005 The block SHALL have port en, input, 1, the count enable.
REQ-006 The block SHALL have port up, input, 1, the direction: 1 counts up, 0 counts down.
REQ-007 The block SHALL have port load, input, 1, a synchronous load strobe.
REQ-008 The block SHALL have port load_num, input, 4*DIGITS, the load value; digit i is bits [4i+3:4i].
REQ-009 The block SHALL have port q_out, output, 4*DIGITS, the registered BCD count.
REQ-010 The block SHALL have port tc, output, 1, terminal count (combinational).
REQ-011 The block SHALL have port load_err, output, 1, a registered one-cycle invalid-load flag.
REQ-012 The block SHALL have display ports as defined in REQ-027 and REQ-028.

Function
REQ-013 Per cycle, the block SHALL apply priority rst > load > en; with none active, the state SHALL hold.
REQ-014 On load, q_out SHALL take load_num on the next edge, per digit; any digit >9 SHALL load as 0.
REQ-015 On load, load_err SHALL be 1 for exactly the following cycle if any load digit was >9, else 0.
REQ-016 While en=1 and up=1, digit 0 SHALL increment each cycle; 9 SHALL wrap to 0 with carry to the next digit.
REQ-017 While en=1 and up=0, digit 0 SHALL decrement each cycle; 0 SHALL wrap to 9 with borrow from the next digit.
REQ-018 Carry and borrow SHALL ripple through all digits in the same cycle; there is no added latency.
REQ-019 The full count SHALL wrap: all-9 up becomes all-0, and all-0 down becomes all-9.
REQ-020 tc SHALL equal en & ((up & all digits 9) | (~up & all digits 0)).
REQ-021 tc SHALL never be asserted while load=1.
REQ-022 A change of up while en=1 SHALL take effect on the same edge; no pipeline hazard is allowed.
REQ-023 The 7-seg encoding SHALL be active-low with bit 7 = dp = 1 (off): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90; any other code SHALL give FF.

Reset
REQ-024 rst=1 SHALL immediately clear q_out to 0, load_err to 0 and the scan counter and digit index to 0.
REQ-025 Reset SHALL take effect mid-count or mid-load without waiting for clk.
REQ-026 After rst deasserts, the first count or load SHALL occur on the next rising clk edge.

Configuration
REQ-027 Macro BCD_COUNTER_SCAN_EN defined: the block SHALL output seg (output, 8) and an (output, DIGITS, one-hot active-low digit select).
- A prescaler counts 0..SCAN_DIV-1.
- On wrap, the digit index advances and wraps from DIGITS-1 to 0.
- seg is the registered encoding of the selected digit, aligned with an in the same cycle.
REQ-028 Macro BCD_COUNTER_SCAN_EN undefined: the block SHALL output seg_all (output, 8*DIGITS) only.
- Byte i is the combinational encoding of digit i.
- There is no prescaler and there are no an or seg ports.
REQ-029 Counting behaviour SHALL be identical with and without the macro.

Verification
REQ-030 The bench SHALL cover count up across carry: DIGITS=4, load 0x0998, en=1, up=1, 3 cycles -> q_out 0x0999, 0x1000, 0x1001.
REQ-031 The bench SHALL cover full wrap and tc:
- Load 0x9999, en=1, up=1 -> tc=1 before the edge; q_out=0x0000 after it.
- Then up=0 -> tc=1, and q_out=0x9999 next cycle.
REQ-032 The bench SHALL cover an invalid load: load_num=0x12A4 -> q_out=0x1204 and load_err=1 for one cycle.
- A following valid load 0x0042 -> load_err=0.
REQ-033 The bench SHALL cover priority: load=1 and en=1 with load_num=0x0005 -> q_out=0x0005 (no increment), tc=0.
REQ-034 The bench SHALL cover async reset: assert rst mid-cycle while counting at 0x0371 -> q_out=0x0000 before the next clk edge and seg byte 0 = C0.
REQ-035 The bench SHALL cover scan with the macro defined: SCAN_DIV=4, count 0x4321.
- an steps 1110, 1101, 1011, 0111 every 4 cycles.
- seg steps F9, A4, B0, 99 in step with an.

Source files
------------

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: DIGITS-wide BCD up/down counter with synchronous load and
// seven-segment display outputs.
//
// Parameters
//   DIGITS    number of BCD digits (1..8)
//   SCAN_DIV  clock cycles each digit is shown in scan mode (>= 2)
//
// Ports
//   clk       clock, all state changes on its rising edge
//   rst       asynchronous active-high reset
//   en        count enable
//   up        direction: 1 = up, 0 = down
//   load      synchronous load strobe (beats en)
//   load_num  load value, digit i in bits [4i+3:4i]; digits > 9 load as 0
//   q_out     registered BCD count
//   tc        terminal count (combinational), never set while load = 1
//   load_err  registered flag, high for the one cycle after a load that
//             contained a digit > 9
//
// Display configuration (macro BCD_COUNTER_SCAN_EN)
//   defined:   seg [7:0]        registered encoding of the selected digit
//              an  [DIGITS-1:0] one-hot active-low digit select, aligned with seg
//   undefined: seg_all [8*DIGITS-1:0] byte i = combinational encoding of digit i
// Segment bytes are active-low with bit 7 (dp) held at 1 (off).

module bcd_counter_n #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_num,
    output logic [4*DIGITS-1:0]   q_out,
    output logic                  tc,
    output logic                  load_err,
`ifdef BCD_COUNTER_SCAN_EN
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
`else
    output logic [8*DIGITS-1:0]   seg_all
`endif
);

    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
    logic                   load_err_q, load_err_d;
    logic                   all_nine, all_zero;

    // Terminal-count detection on the registered count.
    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            all_nine = all_nine & (cnt_q[i] == 4'd9);
            all_zero = all_zero & (cnt_q[i] == 4'd0);
        end
    end

    assign tc = en & ~load & ((up & all_nine) | (~up & all_zero));

    // Next count. The ripple flag carries (up) or borrows (down) from digit i
    // into digit i+1 within the same cycle.
    always_comb begin : next_count
        logic       ripple;
        logic [3:0] ld;
        cnt_d      = cnt_q;
        load_err_d = 1'b0;
        ripple     = 1'b1;
        ld         = 4'd0;
        if (load) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                ld = load_num[4*i +: 4];
                if (ld > 4'd9) begin
                    cnt_d[i]   = 4'd0;
                    load_err_d = 1'b1;
                end else begin
                    cnt_d[i] = ld;
                end
            end
        end else if (en) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (ripple) begin
                    if (up) begin
                        if (cnt_q[i] == 4'd9) begin
                            cnt_d[i] = 4'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                            ripple   = 1'b0;
                        end
                    end else begin
                        if (cnt_q[i] == 4'd0) begin
                            cnt_d[i] = 4'd9;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 4'd1;
                            ripple   = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
        end
    end

    assign q_out    = cnt_q;
    assign load_err = load_err_q;

`ifdef BCD_COUNTER_SCAN_EN
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    seg_q, seg_d;

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        // Encode from next-state values so the registered seg lines up with
        // the digit select derived from idx_q in the same cycle.
        seg_d = seg_enc(cnt_d[idx_d]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hC0;  // encoding of digit 0 after reset
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = ~(DIGITS'(1) << idx_q);
`else
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
        assign seg_all[8*g +: 8] = seg_enc(cnt_q[g]);
    end
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
module tb_bcd_counter_n;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int          MODN     = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_num;
    logic [15:0] q_out;
    logic        tc;
    logic        load_err;
`ifdef BCD_COUNTER_SCAN_EN
    logic [7:0]  seg;
    logic [3:0]  an;
`else
    logic [31:0] seg_all;
`endif

    bcd_counter_n #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_num (load_num),
        .q_out    (q_out),
        .tc       (tc),
        .load_err (load_err),
`ifdef BCD_COUNTER_SCAN_EN
        .seg      (seg),
        .an       (an)
`else
        .seg_all  (seg_all)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: count held as a plain integer 0..9999.
    int m_val = 0;
    bit m_err = 1'b0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    function automatic int pow10(input int e);
        int p = 1;
        for (int k = 0; k < e; k++) p = p * 10;
        return p;
    endfunction

    function automatic int digit_of(input int v, input int i);
        return (v / pow10(i)) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(digit_of(v, i));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check combinational outputs, then
    // advance the model across the edge and check registered outputs.
    task automatic cycle(input bit e, input bit u, input bit l, input logic [15:0] ln);
        bit exp_tc;
        int lv;
        bit lerr;
        logic [31:0] exp_seg;
        en = e; up = u; load = l; load_num = ln;
        #1;
        exp_tc = e && !l && ((u && m_val == MODN - 1) || (!u && m_val == 0));
        check("tc", 32'(tc), 32'(exp_tc));
`ifndef BCD_COUNTER_SCAN_EN
        for (int i = 0; i < 4; i++) exp_seg[8*i +: 8] = seg_tab[digit_of(m_val, i)];
        check("seg_all", seg_all, exp_seg);
`endif
        @(posedge clk);
        if (l) begin
            lv = 0; lerr = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (int'(ln[4*i +: 4]) > 9) lerr = 1'b1;
                else lv = lv + int'(ln[4*i +: 4]) * pow10(i);
            end
            m_val = lv; m_err = lerr;
        end else begin
            if (e) m_val = u ? (m_val + 1) % MODN : (m_val + MODN - 1) % MODN;
            m_err = 1'b0;
        end
        #1;
        check("q_out", 32'(q_out), 32'(to_bcd(m_val)));
        check("load_err", 32'(load_err), 32'(m_err));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_num = '0;
        #2;
        check("rst_q", 32'(q_out), 32'h0);
        check("rst_err", 32'(load_err), 32'h0);
        check("rst_tc", 32'(tc), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Count up across carries.
        cycle(0, 1, 1, 16'h0998);
        cycle(1, 1, 0, 16'h0);
        check("up_0999", 32'(q_out), 32'h0999);
        cycle(1, 1, 0, 16'h0);
        check("up_1000", 32'(q_out), 32'h1000);
        cycle(1, 1, 0, 16'h0);
        check("up_1001", 32'(q_out), 32'h1001);

        // Full wrap both ways, tc before each edge.
        cycle(0, 1, 1, 16'h9999);
        en = 1; up = 1; load = 0; #1;
        check("tc_up_9999", 32'(tc), 32'h1);
        cycle(1, 1, 0, 16'h0);
        check("wrap_0000", 32'(q_out), 32'h0000);
        en = 1; up = 0; #1;
        check("tc_dn_0000", 32'(tc), 32'h1);
        cycle(1, 0, 0, 16'h0);
        check("wrap_9999", 32'(q_out), 32'h9999);

        // Invalid load, then valid load clears the flag.
        cycle(0, 1, 1, 16'h12A4);
        check("bad_load_q", 32'(q_out), 32'h1204);
        check("bad_load_err", 32'(load_err), 32'h1);
        cycle(0, 1, 1, 16'h0042);
        check("good_load_err", 32'(load_err), 32'h0);

        // Load beats enable; tc suppressed while loading.
        cycle(0, 1, 1, 16'h9999);
        en = 1; up = 1; load = 1; load_num = 16'h0005; #1;
        check("prio_tc", 32'(tc), 32'h0);
        cycle(1, 1, 1, 16'h0005);
        check("prio_q", 32'(q_out), 32'h0005);

        // Asynchronous reset in the middle of a counting cycle.
        cycle(0, 1, 1, 16'h0370);
        cycle(1, 1, 0, 16'h0);
        check("pre_rst", 32'(q_out), 32'h0371);
        en = 1; up = 1; load = 0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_q", 32'(q_out), 32'h0000);
`ifdef BCD_COUNTER_SCAN_EN
        check("async_rst_seg", 32'(seg), 32'hC0);
`else
        check("async_rst_seg", 32'(seg_all[7:0]), 32'hC0);
`endif
        #1 rst = 1'b0;
        m_val = 0; m_err = 1'b0;
        cycle(1, 1, 0, 16'h0);
        check("post_rst_first", 32'(q_out), 32'h0001);

`ifdef BCD_COUNTER_SCAN_EN
        // Scan: reset aligns the prescaler, load 4321 on the first edge.
        en = 0; up = 1; load = 1; load_num = 16'h4321;
        rst = 1'b1; #1 rst = 1'b0;
        @(posedge clk); #1;
        load = 0;
        m_val = 4321; m_err = 1'b0;
        check("scan_q", 32'(q_out), 32'h4321);
        for (int k = 1; k <= 16; k++) begin
            int idx;
            idx = (k / int'(SCAN_DIV)) % 4;
            check("scan_an", 32'(an), 32'(4'hF & ~(4'h1 << idx)));
            check("scan_seg", 32'(seg), 32'(seg_tab[digit_of(m_val, idx)]));
            @(posedge clk); #1;
        end
`endif

        // Randomized traffic against the model, biased toward the wrap points.
        for (int n = 0; n < 400; n++) begin
            bit          e, u, l;
            logic [15:0] ln;
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom);
            l = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       ln = 16'h9999;
                1:       ln = 16'h0000;
                default: ln = 16'($urandom);
            endcase
            cycle(e, u, l, ln);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
